// File: rtl/pixel_frame_loader_pkg.sv
// Shared definitions for the pixel frame loader: sync byte, FSM encodings and a width helper.
package pixel_frame_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam int         PIXEL_W   = 24;

    typedef enum logic [2:0] {
        P_SYNC = 3'd0,
        P_IDX  = 3'd1,
        P_R    = 3'd2,
        P_G    = 3'd3,
        P_B    = 3'd4
    } parser_state_t;

    typedef enum logic [1:0] {
        S_GAP  = 2'd0,
        S_LOAD = 2'd1,
        S_REQ  = 2'd2,
        S_WAIT = 2'd3
    } scan_state_t;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/pixel_frame_loader_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module pixel_frame_loader_ram
    import pixel_frame_loader_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [PIXEL_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [PIXEL_W-1:0] rdata
);

    logic [PIXEL_W-1:0] mem_r [DEPTH];

    // Storage array, left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register; a same-cycle write to the same address returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= {PIXEL_W{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/pixel_frame_loader.sv
// Parses AA/idx/R/G/B packets into a pixel buffer and scans it out to writepixel with refresh gaps.
module pixel_frame_loader
    import pixel_frame_loader_pkg::*;
#(
    parameter int NUM_PIXELS     = 10,
    parameter int IDX_W          = 4,
    parameter int REFRESH_CYCLES = 1048576,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    input  logic       i_busy,
    output logic       o_valid,
    output logic [7:0] o_red,
    output logic [7:0] o_green,
    output logic [7:0] o_blue,
    output logic       o_frame_done,
    output logic       o_pkt_err
);

    localparam int GAP_W = clog2_min1(REFRESH_CYCLES);
    localparam int TMO_W = clog2_min1(TIMEOUT_CYCLES);

    parser_state_t      p_state_r;
    logic               drop_r;
    logic [IDX_W-1:0]   idx_r;
    logic [7:0]         red_r;
    logic [7:0]         green_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               pkt_err_r;

    scan_state_t        s_state_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [IDX_W-1:0]   ptr_r;
    logic               valid_r;
    logic               frame_done_r;

    logic               wr_en_s;
    logic [PIXEL_W-1:0] wr_data_s;
    logic               rd_en_s;
    logic [PIXEL_W-1:0] rd_data_s;

    // The B byte lands straight in the buffer together with the held R and G.
    assign wr_en_s   = (p_state_r == P_B) && i_rx_valid && !drop_r;
    assign wr_data_s = {red_r, green_r, i_rx_byte};
    assign rd_en_s   = (s_state_r == S_LOAD);

    pixel_frame_loader_ram #(
        .DEPTH (NUM_PIXELS),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (CLK),
        .rst_n (RST_N),
        .we    (wr_en_s),
        .waddr (idx_r),
        .wdata (wr_data_s),
        .re    (rd_en_s),
        .raddr (ptr_r),
        .rdata (rd_data_s)
    );

    // Packet parser with inter-byte timeout; an AA inside a packet is plain data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_state_r <= P_SYNC;
            drop_r    <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            red_r     <= 8'd0;
            green_r   <= 8'd0;
            tmo_cnt_r <= {TMO_W{1'b0}};
            pkt_err_r <= 1'b0;
        end else begin
            pkt_err_r <= 1'b0;
            if (i_rx_valid) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
                case (p_state_r)
                    P_SYNC: begin
                        if (i_rx_byte == SYNC_BYTE) begin
                            p_state_r <= P_IDX;
                        end
                    end
                    P_IDX: begin
                        idx_r     <= i_rx_byte[IDX_W-1:0];
                        drop_r    <= ({1'b0, i_rx_byte} >= 9'(NUM_PIXELS));
                        p_state_r <= P_R;
                    end
                    P_R: begin
                        red_r     <= i_rx_byte;
                        p_state_r <= P_G;
                    end
                    P_G: begin
                        green_r   <= i_rx_byte;
                        p_state_r <= P_B;
                    end
                    P_B: begin
                        pkt_err_r <= drop_r;
                        p_state_r <= P_SYNC;
                    end
                    default: begin
                        p_state_r <= P_SYNC;
                    end
                endcase
            end else if (p_state_r != P_SYNC) begin
                if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    p_state_r <= P_SYNC;
                    pkt_err_r <= 1'b1;
                    tmo_cnt_r <= {TMO_W{1'b0}};
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                end
            end
        end
    end

    // Frame scanner: refresh gap, then one valid/busy handshake per pixel.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_state_r    <= S_GAP;
            gap_cnt_r    <= {GAP_W{1'b0}};
            ptr_r        <= {IDX_W{1'b0}};
            valid_r      <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (s_state_r)
                S_GAP: begin
                    if (gap_cnt_r == GAP_W'(REFRESH_CYCLES - 1)) begin
                        gap_cnt_r <= {GAP_W{1'b0}};
                        ptr_r     <= {IDX_W{1'b0}};
                        s_state_r <= S_LOAD;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                S_LOAD: begin
                    // Colour appears on the RAM read register at this same edge.
                    valid_r   <= 1'b1;
                    s_state_r <= S_REQ;
                end
                S_REQ: begin
                    if (i_busy) begin
                        valid_r   <= 1'b0;
                        s_state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!i_busy) begin
                        if (ptr_r == IDX_W'(NUM_PIXELS - 1)) begin
                            frame_done_r <= 1'b1;
                            s_state_r    <= S_GAP;
                        end else begin
                            ptr_r     <= ptr_r + IDX_W'(1);
                            s_state_r <= S_LOAD;
                        end
                    end
                end
                default: begin
                    s_state_r <= S_GAP;
                end
            endcase
        end
    end

    assign o_valid      = valid_r;
    assign o_red        = rd_data_s[23:16];
    assign o_green      = rd_data_s[15:8];
    assign o_blue       = rd_data_s[7:0];
    assign o_frame_done = frame_done_r;
    assign o_pkt_err    = pkt_err_r;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Randomized bench for pixel_frame_loader against a buffer-level reference model.
module tb_pixel_frame_loader;

    localparam int NPIX     = 10;
    localparam int REFRESH  = 64;
    localparam int TMO      = 100;
    localparam int BUSY_LEN = 30;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       rx_valid = 1'b0;
    logic       busy = 1'b0;
    logic       o_valid;
    logic [7:0] o_red;
    logic [7:0] o_green;
    logic [7:0] o_blue;
    logic       o_frame_done;
    logic       o_pkt_err;

    pixel_frame_loader #(
        .NUM_PIXELS     (NPIX),
        .IDX_W          (4),
        .REFRESH_CYCLES (REFRESH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .i_rx_byte    (rx_byte),
        .i_rx_valid   (rx_valid),
        .i_busy       (busy),
        .o_valid      (o_valid),
        .o_red        (o_red),
        .o_green      (o_green),
        .o_blue       (o_blue),
        .o_frame_done (o_frame_done),
        .o_pkt_err    (o_pkt_err)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail = 0;
    int          frames = 0;
    int          exp_err = 0;
    int          seen_err = 0;
    int          mon_pix = 0;
    logic        hold_accept = 1'b0;
    logic [23:0] ref_mem   [NPIX];
    logic [23:0] last_seen [NPIX];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // writepixel model: accepts a request and stays busy for BUSY_LEN cycles
    initial begin : writepixel_model
        int left;
        left = 0;
        forever begin
            @(negedge CLK);
            if (left != 0) begin
                left--;
                if (left == 0) busy = 1'b0;
            end else if (o_valid && !hold_accept) begin
                busy = 1'b1;
                left = BUSY_LEN;
            end
        end
    end

    // Frame monitor: gap length, pixel order/colour, hold stability, frame length
    initial begin : monitor
        int          since;
        logic        prev_valid;
        logic [23:0] prev_rgb;
        logic [23:0] rgb;
        since = 0;
        prev_valid = 1'b0;
        prev_rgb = 24'd0;
        for (int i = 0; i < NPIX; i++) last_seen[i] = 24'hFFFFFF;
        forever begin
            @(posedge CLK);
            #1;
            rgb = {o_red, o_green, o_blue};
            if (!RST_N) begin
                since = 0;
                mon_pix = 0;
                prev_valid = 1'b0;
            end else begin
                since++;
                if (o_pkt_err) seen_err++;
                if (o_valid && !prev_valid) begin
                    if (mon_pix == 0) check_value("gap_len", since, 65);
                    if (mon_pix < NPIX) begin
                        check_value("pixel_rgb", rgb, ref_mem[mon_pix]);
                        last_seen[mon_pix] = rgb;
                    end else begin
                        check_value("req_past_end", mon_pix, NPIX - 1);
                    end
                    mon_pix++;
                end else if (o_valid && prev_valid) begin
                    check_value("hold_rgb", rgb, prev_rgb);
                end
                if (o_frame_done) begin
                    check_value("frame_len", mon_pix, NPIX);
                    frames++;
                    mon_pix = 0;
                    since = 0;
                end
                prev_valid = o_valid;
                prev_rgb = rgb;
            end
        end
    end

    // Sends one packet (caller at a negedge); the model buffer updates after the B edge
    task automatic send_packet(input logic [7:0] idx, input logic [23:0] rgb, input int max_gap);
        logic [7:0] pkt [5];
        pkt[0] = 8'hAA;
        pkt[1] = idx;
        pkt[2] = rgb[23:16];
        pkt[3] = rgb[15:8];
        pkt[4] = rgb[7:0];
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            rx_byte = pkt[k];
            rx_valid = 1'b1;
            @(posedge CLK);
            #1;
            if (k == 4) check_value("pkt_err_at_b", o_pkt_err, (idx >= NPIX));
            @(negedge CLK);
            rx_valid = 1'b0;
            if (k < 4) repeat ($urandom_range(max_gap, 0)) @(negedge CLK);
        end
        if (idx < NPIX) ref_mem[idx] = rgb;
        else exp_err++;
    endtask

    task automatic send_raw(input logic [7:0] b);
        @(negedge CLK);
        rx_byte = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int target;
        int budget;
        target = frames + n;
        budget = 0;
        while (frames < target && budget < 600 * n + 600) begin
            @(posedge CLK);
            budget++;
        end
        #2;
        check_value("wait_frames", (frames >= target), 1'b1);
    endtask

    initial begin : watchdog
        #(600_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          cyc;
        int          early;
        logic [7:0]  junk;
        logic [23:0] held;
        for (int i = 0; i < NPIX; i++) ref_mem[i] = 24'd0;

        // Reset state
        repeat (3) @(negedge CLK);
        check_value("rst_valid", o_valid, 1'b0);
        check_value("rst_rgb", {o_red, o_green, o_blue}, 24'd0);
        check_value("rst_done", o_frame_done, 1'b0);
        check_value("rst_err", o_pkt_err, 1'b0);
        RST_N = 1'b1;

        // 1: first request 65 cycles after release, blank colour
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
        end while (!o_valid && cyc < 300);
        check_value("t1_first_valid", cyc, 65);
        check_value("t1_rgb", {o_red, o_green, o_blue}, 24'd0);
        wait_frames(1);

        // 2: single pixel update
        send_packet(8'd3, 24'h112233, 3);
        wait_frames(2);
        check_value("t2_px3", last_seen[3], 24'h112233);
        check_value("t2_px2", last_seen[2], 24'h000000);

        // 3: bad index dropped, next packet fine
        send_packet(8'd10, 24'h010203, 3);
        send_packet(8'd0, 24'h5A6B7C, 2);
        wait_frames(2);
        check_value("t3_px0", last_seen[0], 24'h5A6B7C);

        // 4: timeout after partial packet
        send_raw(8'hAA);
        send_raw(8'h05);
        send_raw(8'h44);
        early = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) begin
                @(posedge CLK);
                #1;
            end else begin
                @(posedge CLK);
                #1;
            end
            if (k < 100) early += o_pkt_err;
            else check_value("t4_tmo_pulse", o_pkt_err, 1'b1);
        end
        check_value("t4_tmo_early", early, 0);
        exp_err++;
        repeat (50) @(negedge CLK);
        send_packet(8'd5, 24'h010203, 0);
        wait_frames(2);
        check_value("t4_px5", last_seen[5], 24'h010203);

        // 0xAA inside a packet is data, also as an index
        send_packet(8'd7, 24'hAAAAAA, 0);
        send_packet(8'hAA, 24'h123456, 0);

        // Random traffic concurrent with scanning
        repeat (30) begin
            if ($urandom_range(3, 0) == 0) begin
                junk = 8'($urandom_range(255, 0));
                if (junk == 8'hAA) junk = 8'h55;
                send_raw(junk);
            end
            send_packet(8'($urandom_range(12, 0)), 24'($urandom), 20);
            repeat ($urandom_range(60, 0)) @(negedge CLK);
        end
        wait_frames(2);
        check_value("rnd_px7", last_seen[7], ref_mem[7]);

        // 5: request held while busy stays low
        hold_accept = 1'b1;
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
        end while (!(o_valid && !busy) && cyc < 2000);
        check_value("t5_got_req", o_valid, 1'b1);
        held = {o_red, o_green, o_blue};
        early = 0;
        repeat (200) begin
            @(posedge CLK);
            #1;
            if (!o_valid) early++;
        end
        check_value("t5_valid_held", early, 0);
        check_value("t5_rgb_held", {o_red, o_green, o_blue}, held);
        hold_accept = 1'b0;
        @(negedge CLK);
        #1;
        check_value("t5_busy_up", busy, 1'b1);
        @(posedge CLK);
        #1;
        check_value("t5_valid_drop", o_valid, 1'b0);

        // 6: reset during S_WAIT of pixel 4
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
        end while (!(mon_pix == 5 && !o_valid && busy) && cyc < 2000);
        check_value("t6_reach_px4", mon_pix, 5);
        #2;
        RST_N = 1'b0;
        #1;
        check_value("t6_valid", o_valid, 1'b0);
        check_value("t6_rgb", {o_red, o_green, o_blue}, 24'd0);
        check_value("t6_done", o_frame_done, 1'b0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
        end while (!o_valid && cyc < 300);
        check_value("t6_restart_gap", cyc, 65);
        check_value("t6_px0", {o_red, o_green, o_blue}, ref_mem[0]);
        wait_frames(1);

        check_value("pkt_err_count", seen_err, exp_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
